// File: rtl/bw_pkg.sv
// Shared types, error-bit positions and helpers for the write-bandwidth run controller.
package bw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } bw_state_e;

  localparam int ERR_BRESP     = 0;
  localparam int ERR_TIMEOUT   = 1;
  localparam int ERR_UNDERFLOW = 2;

  function automatic int MS_CYCLES(input int freq_hz);
    return freq_hz / 1000;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bw_ms_tick.sv
// Millisecond prescaler: one-cycle tick every MS_CYCLES(FREQ_HZ) cycles, held at phase 0 by clear.
module bw_ms_tick
  import bw_pkg::*;
#(
  parameter int FREQ_HZ = 250000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);
  localparam int MS   = (MS_CYCLES(FREQ_HZ) > 0) ? MS_CYCLES(FREQ_HZ) : 1;
  localparam int CW   = (MS > 1) ? $clog2(MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !clear && (r_cnt == LAST);

endmodule

// File: rtl/write_bw_ctrl.sv
// Run controller for the PCIe write-bandwidth generator: times the enable window,
// counts AW / W-last / B handshakes, drains outstanding bursts and reports results.
module write_bw_ctrl
  import bw_pkg::*;
#(
  parameter int FREQ_HZ       = 250000000,
  parameter int DRAIN_QUIET   = 16,
  parameter int DRAIN_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] duration_ms,
  input  logic        aw_hs,
  input  logic        wlast_hs,
  input  logic        b_hs,
  input  logic [1:0]  bresp,
  output logic        enable_write,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err,
  output logic [31:0] bursts_issued,
  output logic [31:0] bursts_completed,
  output logic [31:0] wlast_count,
  output logic [31:0] elapsed_cycles
);
  bw_state_e   r_state;
  logic        r_enable;
  logic        r_busy;
  logic        r_done;
  logic [2:0]  r_err;
  logic [31:0] r_issued;
  logic [31:0] r_completed;
  logic [31:0] r_wlast;
  logic [31:0] r_elapsed;
  logic [31:0] r_run_cycles;
  logic [31:0] r_outstanding;
  logic [31:0] r_quiet;
  logic [31:0] r_drain_cycles;
  logic [15:0] r_ms_left;

  logic        w_tick;
  logic        w_presc_clear;
  logic        w_active;
  logic        w_underflow;
  logic        w_quiet_done;
  logic        w_timeout;
  logic        w_last_ms;
  logic [31:0] w_run_next;
  logic [31:0] w_out_next;
  logic [31:0] w_quiet_next;
  logic [31:0] w_drain_next;

  // Prescaler phase restarts at every RUN entry so the window is exactly duration_ms ms.
  assign w_presc_clear = (r_state != ST_RUN);

  bw_ms_tick #(
    .FREQ_HZ(FREQ_HZ)
  ) u_ms_tick (
    .clk   (clk),
    .resetn(resetn),
    .clear (w_presc_clear),
    .tick  (w_tick)
  );

  assign w_active     = (r_state != ST_IDLE);
  assign w_run_next   = sat_inc(r_run_cycles);
  assign w_quiet_next = (r_outstanding == '0) ? sat_inc(r_quiet) : '0;
  assign w_drain_next = sat_inc(r_drain_cycles);
  assign w_quiet_done = (w_quiet_next >= 32'(DRAIN_QUIET));
  assign w_timeout    = (w_drain_next >= 32'(DRAIN_TIMEOUT));
  assign w_last_ms    = w_tick && (r_ms_left <= 16'd1);

  // Outstanding tracker: a same-cycle AW and B cancel; a lone B at zero is an underflow.
  always_comb begin
    w_out_next  = r_outstanding;
    w_underflow = 1'b0;
    if (aw_hs && !b_hs) begin
      w_out_next = sat_inc(r_outstanding);
    end else if (b_hs && !aw_hs) begin
      if (r_outstanding == '0) begin
        w_underflow = 1'b1;
      end else begin
        w_out_next = r_outstanding - 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= ST_IDLE;
      r_enable       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= '0;
      r_issued       <= '0;
      r_completed    <= '0;
      r_wlast        <= '0;
      r_elapsed      <= '0;
      r_run_cycles   <= '0;
      r_outstanding  <= '0;
      r_quiet        <= '0;
      r_drain_cycles <= '0;
      r_ms_left      <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_active) begin
        if (aw_hs) r_issued <= sat_inc(r_issued);
        if (wlast_hs) r_wlast <= sat_inc(r_wlast);
        if (b_hs) begin
          r_completed <= sat_inc(r_completed);
          r_elapsed   <= w_run_next;
          if (bresp != 2'b00) r_err[ERR_BRESP] <= 1'b1;
        end
        if (w_underflow) r_err[ERR_UNDERFLOW] <= 1'b1;
        r_outstanding <= w_out_next;
        r_run_cycles  <= w_run_next;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_err          <= '0;
            r_issued       <= '0;
            r_completed    <= '0;
            r_wlast        <= '0;
            r_elapsed      <= '0;
            r_run_cycles   <= '0;
            r_outstanding  <= '0;
            r_quiet        <= '0;
            r_drain_cycles <= '0;
            r_ms_left      <= duration_ms;
            if (duration_ms == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state  <= ST_RUN;
              r_busy   <= 1'b1;
              r_enable <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_tick) r_ms_left <= r_ms_left - 16'd1;
          if (abort || w_last_ms) begin
            r_state        <= ST_DRAIN;
            r_enable       <= 1'b0;
            r_quiet        <= '0;
            r_drain_cycles <= '0;
          end
        end
        ST_DRAIN: begin
          r_quiet        <= w_quiet_next;
          r_drain_cycles <= w_drain_next;
          if (w_quiet_done || w_timeout) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (!w_quiet_done) r_err[ERR_TIMEOUT] <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_enable <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign enable_write     = r_enable;
  assign busy             = r_busy;
  assign done             = r_done;
  assign err              = r_err;
  assign bursts_issued    = r_issued;
  assign bursts_completed = r_completed;
  assign wlast_count      = r_wlast;
  assign elapsed_cycles   = r_elapsed;

endmodule

// File: tb/tb_write_bw_ctrl.sv
// Bench for write_bw_ctrl at 10 cycles/ms: expected run results are queued when a run is
// started and compared when the controller pulses done.
module tb_write_bw_ctrl;

  localparam int RUN_BUDGET = 300;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] duration_ms = '0;
  logic        aw_hs = 1'b0;
  logic        wlast_hs = 1'b0;
  logic        b_hs = 1'b0;
  logic [1:0]  bresp = '0;
  logic        enable_write;
  logic        busy;
  logic        done;
  logic [2:0]  err;
  logic [31:0] bursts_issued;
  logic [31:0] bursts_completed;
  logic [31:0] wlast_count;
  logic [31:0] elapsed_cycles;

  typedef struct {
    string name;
    int    en;
    int    busy;
    int    issued;
    int    completed;
    int    wlast;
    int    elapsed;
    int    err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  write_bw_ctrl #(
    .FREQ_HZ      (10000),
    .DRAIN_QUIET  (4),
    .DRAIN_TIMEOUT(50)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .start           (start),
    .abort           (abort),
    .duration_ms     (duration_ms),
    .aw_hs           (aw_hs),
    .wlast_hs        (wlast_hs),
    .b_hs            (b_hs),
    .bresp           (bresp),
    .enable_write    (enable_write),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .bursts_issued   (bursts_issued),
    .bursts_completed(bursts_completed),
    .wlast_count     (wlast_count),
    .elapsed_cycles  (elapsed_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One run: generator issues AW+W-last every 4th enabled cycle, B 8 cycles later.
  // simul selects a fixed pattern: AW+B together in cycle 1, lone B in cycle 3.
  task automatic do_run(input exp_t e, input int dur, input int abort_at, input int late_aw,
                        input int bad_b, input bit hold_b, input bit simul);
    int   b_due[$];
    int   en_cnt   = 0;
    int   busy_cnt = 0;
    int   done_at  = 0;
    int   nb       = 0;
    exp_t x;
    @(negedge clk);
    start       = 1'b1;
    duration_ms = 16'(dur);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= RUN_BUDGET; k++) begin
      if (enable_write) en_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_at = k;
        break;
      end
      aw_hs    = 1'b0;
      wlast_hs = 1'b0;
      b_hs     = 1'b0;
      bresp    = 2'b00;
      if (!simul) begin
        if ((enable_write && (((k - 1) % 4) == 0)) || (k == late_aw)) begin
          aw_hs    = 1'b1;
          wlast_hs = 1'b1;
          if (!hold_b) b_due.push_back(k + 8);
        end
        if ((b_due.size() > 0) && (b_due[0] == k)) begin
          void'(b_due.pop_front());
          b_hs = 1'b1;
          nb++;
          if (nb == bad_b) bresp = 2'b10;
        end
      end else begin
        if (k == 1) begin
          aw_hs    = 1'b1;
          wlast_hs = 1'b1;
          b_hs     = 1'b1;
        end
        if (k == 3) b_hs = 1'b1;
      end
      abort = (k == abort_at);
      @(negedge clk);
    end
    aw_hs    = 1'b0;
    wlast_hs = 1'b0;
    b_hs     = 1'b0;
    bresp    = 2'b00;
    abort    = 1'b0;
    x = sb_q.pop_front();
    check_eq({x.name, "/done_at"},   done_at,          x.busy + 1);
    check_eq({x.name, "/en_cycles"}, en_cnt,           x.en);
    check_eq({x.name, "/busy"},      busy_cnt,         x.busy);
    check_eq({x.name, "/issued"},    bursts_issued,    x.issued);
    check_eq({x.name, "/completed"}, bursts_completed, x.completed);
    check_eq({x.name, "/wlast"},     wlast_count,      x.wlast);
    check_eq({x.name, "/elapsed"},   elapsed_cycles,   x.elapsed);
    check_eq({x.name, "/err"},       32'(err),         x.err);
    $display("run %s: en=%0d busy=%0d done_at=%0d issued=%0d completed=%0d wlast=%0d elapsed=%0d err=%03b",
             x.name, en_cnt, busy_cnt, done_at, bursts_issued, bursts_completed, wlast_count,
             elapsed_cycles, err);
    @(negedge clk);
    check_eq({x.name, "/done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   seen_done;

    repeat (3) @(negedge clk);
    check_eq("rst/en",        32'(enable_write), 32'd0);
    check_eq("rst/busy",      32'(busy),         32'd0);
    check_eq("rst/done",      32'(done),         32'd0);
    check_eq("rst/err",       32'(err),          32'd0);
    check_eq("rst/issued",    bursts_issued,     32'd0);
    check_eq("rst/completed", bursts_completed,  32'd0);
    check_eq("rst/wlast",     wlast_count,       32'd0);
    check_eq("rst/elapsed",   elapsed_cycles,    32'd0);
    $display("reset: en=%0d busy=%0d done=%0d err=%03b", enable_write, busy, done, err);
    resetn = 1'b1;

    e = '{"basic", 30, 41, 8, 8, 8, 37, 0};
    do_run(e, 3, 0, 0, 0, 1'b0, 1'b0);

    e = '{"zero", 0, 0, 0, 0, 0, 0, 0};
    do_run(e, 0, 0, 0, 0, 1'b0, 1'b0);

    e = '{"abort", 5, 19, 3, 3, 3, 15, 0};
    do_run(e, 10, 5, 7, 0, 1'b0, 1'b0);

    e = '{"badresp", 10, 21, 3, 3, 3, 17, 1};
    do_run(e, 1, 0, 0, 2, 1'b0, 1'b0);

    e = '{"timeout", 10, 60, 3, 0, 3, 0, 2};
    do_run(e, 1, 0, 0, 0, 1'b1, 1'b0);

    e = '{"simul", 20, 24, 1, 2, 1, 3, 4};
    do_run(e, 2, 0, 0, 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    start       = 1'b1;
    duration_ms = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("midrst/pre_en", 32'(enable_write), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_eq("midrst/en",   32'(enable_write), 32'd0);
    check_eq("midrst/busy", 32'(busy),         32'd0);
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    resetn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_eq("midrst/no_done",  seen_done,         32'd0);
    check_eq("midrst/en_after", 32'(enable_write), 32'd0);
    $display("midrst: en=%0d busy=%0d done_seen=%0d", enable_write, busy, seen_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/write_bw_ctrl.md
# write_bw_ctrl

Run controller for the PCIe write-bandwidth generator. It accepts a start command and a run length in milliseconds, then drives the generator's `enable_write` for exactly that window. It monitors the generator's AW, W-last and B handshakes, waits for all outstanding bursts to drain, and reports burst counts, elapsed cycles and error status to the register block for bandwidth computation by software.

## Interface
Parameters:
- `FREQ_HZ`, 250000000: clock frequency; one millisecond is `FREQ_HZ/1000` cycles.
- `DRAIN_QUIET`, 16: cycles with zero outstanding bursts required before a drain completes.
- `DRAIN_TIMEOUT`, 1000000: maximum number of DRAIN cycles before the timeout error.

Ports:
- `clk` in 1: the single clock.
- `resetn` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle command; ignored while `busy`.
- `abort` in 1: ends RUN early; ignored in other states.
- `duration_ms` in 16: run length, sampled on the accepted `start`.
- `aw_hs` in 1: AWVALID&AWREADY of the generator.
- `wlast_hs` in 1: WVALID&WREADY&WLAST.
- `b_hs` in 1: BVALID&BREADY.
- `bresp` in 2: BRESP, valid with `b_hs`.
- `enable_write` out 1: enable to the generator.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when a run completes.
- `err` out 3: sticky flags [0] bad BRESP, [1] drain timeout, [2] B underflow; cleared by accepted `start`.
- `bursts_issued` out 32: AW handshakes counted this run.
- `bursts_completed` out 32: B handshakes counted this run.
- `wlast_count` out 32: W-last handshakes counted this run.
- `elapsed_cycles` out 32: cycles from the first RUN cycle through the last completing `b_hs`.

## Operation
- States are IDLE, RUN and DRAIN. All outputs are registered.
- **IDLE.** On `start`:
  - clear all counters and `err`, and load the ms down-counter.
  - If `duration_ms`==0, stay in IDLE and pulse `done` next cycle; `enable_write` is never asserted.
  - Otherwise go to RUN.
- **RUN.**
  - `enable_write`=1.
  - The prescaler raises a tick every `FREQ_HZ/1000` cycles and the ms counter decrements on each tick.
  - When the counter reaches 0, or `abort` is high, go to DRAIN.
- **DRAIN.**
  - `enable_write`=0.
  - Counters keep counting, because the generator can issue in-flight AWs after the enable drops.
  - Exit to IDLE with a `done` pulse when either:
    - `outstanding`==0 for `DRAIN_QUIET` consecutive cycles, or
    - `DRAIN_TIMEOUT` cycles have elapsed; this sets `err[1]`.
- **Outstanding count.** `outstanding` is 32 bits: +1 on `aw_hs`, −1 on `b_hs`, unchanged when both occur in the same cycle.
  - A `b_hs` with `outstanding`==0 and no simultaneous `aw_hs` sets `err[2]`; the counter stays at 0.
- **Counters.** All counters saturate at 0xFFFF_FFFF and never wrap.
  - `elapsed_cycles` is latched from the free-running run-cycle counter on every `b_hs`.
- **BRESP errors.** A `b_hs` with `bresp`!=0 sets `err[0]`.
- **Results.** Results hold in IDLE until the next accepted `start`.

## Timing
- **Reset values.** `enable_write`=0, `busy`=0, `done`=0, `err`=0, all counters 0, state IDLE.
- **Start latency.** `start` is sampled at edge N; `busy` and `enable_write` are high from N+1.
- **RUN length.** `enable_write` is high for exactly `duration_ms*FREQ_HZ/1000` cycles; the prescaler is reset on start.
- **Abort latency.** `abort` at edge N drops `enable_write` at N+1.
- **Done timing.** `done` rises in the same cycle that `busy` falls, and lasts one cycle.
- **Results stable.** All result outputs are stable from the `done` cycle onward.
- **Reset mid-run.** Reset asserted at any point forces the reset values immediately; no `done` is produced.
- **Start during `done`.** A `start` in the `done` cycle is accepted, because the state is already IDLE.

## Structure
- **Package `bw_pkg`:**
  - state enum (IDLE/RUN/DRAIN);
  - `ERR_BRESP`/`ERR_TIMEOUT`/`ERR_UNDERFLOW` bit indices;
  - `MS_CYCLES = FREQ_HZ/1000` function.
- **Sub-module `bw_ms_tick`:** prescaler with `clear` input and one-cycle `tick` output, parameterized by `FREQ_HZ`.
- **Top.** The FSM, counters and outstanding tracker stay in the top module.

## Test plan
Use `FREQ_HZ`=10000 (10 cycles/ms) and `DRAIN_QUIET`=4.
- **Basic run.** `duration_ms`=3, model with 1 AW per 4 cycles and B 8 cycles later → `enable_write` high for exactly 30 cycles; `bursts_issued`==`bursts_completed`==`wlast_count`; `err`=0; one `done` pulse.
- **Zero duration.** `duration_ms`=0 → `enable_write` never high; `done` one cycle after start; counters 0.
- **Abort.** `abort` in the 5th RUN cycle → `enable_write` low from cycle 6; drain completes; counts match.
- **Bad BRESP.** One `bresp`=2 → `err`=3'b001 after done.
- **Drain timeout.** B withheld with `DRAIN_TIMEOUT`=50 → `done` after 50 DRAIN cycles; `err[1]`=1.
- **Reset and simultaneous events.**
  - Async `resetn` low mid-RUN → `enable_write` drops without waiting for a clock edge; no `done`.
  - Simultaneous `aw_hs`+`b_hs` → `outstanding` unchanged.
  - `b_hs` with `outstanding`==0 → `err[2]`=1.
